vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Produces the VGA raster timing that feeds the graphics engine: pixel coordinates `x`/`y`, `h_sync`, `v_sync`, the `frame_active` blanking qualifier, and line/frame start strobes. It is the source end of the coordinate/sync interface the graphics engine consumes. The default configuration is 640x480@60 (800x525 total) at a 25 MHz pixel rate. All outputs are registered and mutually coherent on every clock.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: asserted sync level (0 = negative sync).
- `clk` in, 1 bit: pixel clock. One clock domain.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `ce` in, 1 bit: pixel advance enable. When low, all state holds.
- `x` out, 10 bits: horizontal counter, 0..H_TOTAL-1.
- `y` out, 10 bits: vertical counter, 0..V_TOTAL-1.
- `h_sync` out, 1 bit: horizontal sync at the `SYNC_POL` level.
- `v_sync` out, 1 bit: vertical sync at the `SYNC_POL` level.
- `frame_active` out, 1 bit: high when x<H_ACTIVE and y<V_ACTIVE.
- `line_start` out, 1 bit: high when x==0.
- `frame_start` out, 1 bit: high when x==0 and y==0.

## Operation
- H_TOTAL = sum of the four H_* parameters (default 800). V_TOTAL = sum of the four V_* parameters (default 525).
- An elaboration-time check fails if either total is greater than 1024.
- Horizontal phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - ACTIVE covers x in [0, H_ACTIVE).
  - FRONT covers [H_ACTIVE, H_ACTIVE+H_FRONT).
  - SYNC covers the next H_SYNC pixels.
  - BACK covers the remainder of the line.
  - Default SYNC is x = 656..751.
- Vertical phase FSM has the same four phases over `y`. Default SYNC is y = 490..491.
- On each `clk` edge with `ce`=1:
  - `x` increments.
  - At x==H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - At y==V_TOTAL-1 together with the x wrap, `y` wraps to 0.
- `ce`=0 freezes counters, phases and every output, including the strobes.
- Outputs are computed from next-state values and registered, so in any cycle all outputs describe the `(x,y)` presented in that same cycle.
- `h_sync` equals `SYNC_POL` while the horizontal phase is SYNC, and `~SYNC_POL` otherwise. `v_sync` follows the same rule on the vertical phase; it is line-aligned and changes only on the cycle where x becomes 0.
- Strobes are position levels. With `ce` held high they are one-cycle pulses: `line_start` every H_TOTAL cycles, `frame_start` every H_TOTAL*V_TOTAL cycles.
- Reset state is the last pixel of the frame:
  - x=H_TOTAL-1, y=V_TOTAL-1, both phases BACK.
  - `frame_active`=0, `h_sync`=`v_sync`=~SYNC_POL.
  - `line_start`=`frame_start`=0.
- Reset mid-frame forces the reset state immediately (asynchronous); no partial line completes.

## Timing
- Latency from reset deassertion: the first `clk` edge with `ce`=1 presents (0,0) with `frame_start`=1, `line_start`=1 and `frame_active`=1.
- Output changes occur only on `clk` edges. There are no combinational paths from `ce` to outputs.
- `v_sync` edges coincide with `x`=0 cycles.
- Downstream logic that counts frames on a `v_sync` edge therefore sees exactly one edge of each kind per frame.
- Frame period is H_TOTAL*V_TOTAL enabled cycles: 420 000 by default.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants;
  - the phase enum {ACTIVE, FRONT, SYNC, BACK};
  - the 10-bit coordinate width.
- Sub-module `vga_axis_counter`:
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Inputs: `clk`, `rst`, `step`.
  - Outputs: `count`, `phase`, `wrap`.
  - It is instantiated for horizontal with `step=ce`, and for vertical with `step=ce & h_wrap`.
- Top level registers the sync, active and strobe outputs from the next-state phase values.

## Test plan
- Release reset, `ce`=1: the first cycle shows (0,0) with `frame_start`=1 and `frame_active`=1. The next cycle shows (1,0) with `frame_start`=0.
- Run one line: `h_sync`=0 exactly for x=656..751 (96 cycles), `frame_active` falls at x=640, `line_start` recurs after 800 cycles.
- Run one frame: `v_sync`=0 for lines 490–491 (1600 cycles), transitioning at x=0. `frame_start` recurs after 420 000 cycles.
- Toggle `ce` 1-of-2 cycles: coordinates advance only on enabled edges, outputs hold in between, and the frame takes 840 000 clocks.
- Assert `rst` at (300,200): outputs go at once to (799,524), syncs high, `frame_active`=0. Resuming starts at (0,0).
- Override to 8/2/4/2 by 4/1/2/1 (16x8 total) with SYNC_POL=1: `h_sync`=1 for x=10..13, `v_sync`=1 for y=5..6, and the frame is 128 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing types and defaults.
// Holds 640x480@60 constants, the coordinate width and the phase enum.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Ports: clk, rst, step in; count, phase, wrap, next_count, next_phase out.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  output coord_t count,
  output phase_e phase,
  output logic   wrap,
  output coord_t next_count,
  output phase_e next_phase
);

  localparam int     TOTAL    = ACTIVE + FRONT + SYNC + BACK;
  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t FP_START = coord_t'(ACTIVE);
  localparam coord_t SY_START = coord_t'(ACTIVE + FRONT);
  localparam coord_t BP_START = coord_t'(ACTIVE + FRONT + SYNC);

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_seg
    $error("vga_axis_counter: every segment needs at least one unit");
  end

  assign wrap = (count == LAST);

  // next_* is the value held after the coming edge, so the top can
  // register its outputs coherently with count/phase.
  always_comb begin
    next_count = count;
    next_phase = phase;
    if (step) begin
      next_count = wrap ? '0 : count + coord_t'(1);
      unique case (phase)
        PH_ACTIVE: if (next_count == FP_START) next_phase = PH_FRONT;
        PH_FRONT:  if (next_count == SY_START) next_phase = PH_SYNC;
        PH_SYNC:   if (next_count == BP_START) next_phase = PH_BACK;
        PH_BACK:   if (wrap)                   next_phase = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LAST;
      phase <= PH_BACK;
    end else if (step) begin
      count <= next_count;
      phase <= next_phase;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: coordinates, syncs, blanking and strobes.
// Ports: clk, rst, ce in; x, y, h_sync, v_sync, frame_active, line/frame_start out.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               h_sync,
  output logic               v_sync,
  output logic               frame_active,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: raster total exceeds coordinate range");
  end

  phase_e h_phase;
  phase_e v_phase;
  phase_e h_nphase;
  phase_e v_nphase;
  coord_t h_ncount;
  coord_t v_ncount;
  logic   h_wrap;
  logic   v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clk        (clk),
    .rst        (rst),
    .step       (ce),
    .count      (x),
    .phase      (h_phase),
    .wrap       (h_wrap),
    .next_count (h_ncount),
    .next_phase (h_nphase)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clk        (clk),
    .rst        (rst),
    .step       (ce & h_wrap),
    .count      (y),
    .phase      (v_phase),
    .wrap       (v_wrap),
    .next_count (v_ncount),
    .next_phase (v_nphase)
  );

  // Registered from the next-state values so every output
  // describes the (x,y) visible in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync       <= ~SYNC_POL;
      v_sync       <= ~SYNC_POL;
      frame_active <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (ce) begin
      h_sync       <= (h_nphase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      v_sync       <= (v_nphase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      frame_active <= (h_nphase == PH_ACTIVE) && (v_nphase == PH_ACTIVE);
      line_start   <= (h_ncount == '0);
      frame_start  <= (h_ncount == '0) && (v_ncount == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen.
// Runs default 640x480 and a 16x8 positive-sync instance against a position model.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, fa_a, ls_a, fs_a;
  logic       hs_b, vs_b, fa_b, ls_b, fs_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ax, ay, bx, by;

  always #20 clk = ~clk;

  vga_timing_gen dut_a (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .x            (x_a),
    .y            (y_a),
    .h_sync       (hs_a),
    .v_sync       (vs_a),
    .frame_active (fa_a),
    .line_start   (ls_a),
    .frame_start  (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FRONT  (2),
    .H_SYNC   (4),
    .H_BACK   (2),
    .V_ACTIVE (4),
    .V_FRONT  (1),
    .V_SYNC   (2),
    .V_BACK   (1),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .x            (x_b),
    .y            (y_b),
    .h_sync       (hs_b),
    .v_sync       (vs_b),
    .frame_active (fa_b),
    .line_start   (ls_b),
    .frame_start  (fs_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  // Expected outputs follow directly from the raster position.
  task automatic check_pos(
    input string w,
    input logic [9:0] gx, input logic [9:0] gy,
    input logic ghs, input logic gvs, input logic gfa,
    input logic gls, input logic gfs,
    input int px, input int py,
    input int ha, input int hf, input int hsw,
    input int va, input int vf, input int vsw,
    input bit pol);
    bit in_hs, in_vs;
    in_hs = (px >= ha + hf) && (px < ha + hf + hsw);
    in_vs = (py >= va + vf) && (py < va + vf + vsw);
    check({w, ".x"}, gx, px);
    check({w, ".y"}, gy, py);
    check({w, ".h_sync"}, ghs, in_hs ? pol : !pol);
    check({w, ".v_sync"}, gvs, in_vs ? pol : !pol);
    check({w, ".frame_active"}, gfa, (px < ha) && (py < va));
    check({w, ".line_start"}, gls, px == 0);
    check({w, ".frame_start"}, gfs, (px == 0) && (py == 0));
  endtask

  task automatic check_both();
    check_pos("a", x_a, y_a, hs_a, vs_a, fa_a, ls_a, fs_a,
              ax, ay, 640, 16, 96, 480, 10, 2, 1'b0);
    check_pos("b", x_b, y_b, hs_b, vs_b, fa_b, ls_b, fs_b,
              bx, by, 8, 2, 4, 4, 1, 2, 1'b1);
  endtask

  task automatic adv(inout int px, inout int py,
                     input int ht, input int vt);
    if (px == ht - 1) begin
      px = 0;
      py = (py == vt - 1) ? 0 : py + 1;
    end else begin
      px = px + 1;
    end
  endtask

  task automatic model_reset();
    ax = 799;
    ay = 524;
    bx = 15;
    by = 7;
  endtask

  task automatic step(input bit c);
    @(negedge clk);
    ce = c;
    @(posedge clk);
    cyc++;
    if (c && !rst) begin
      adv(ax, ay, 800, 525);
      adv(bx, by, 16, 8);
    end
    #1;
    check_both();
  endtask

  // Reset lands between edges; outputs must move without a clock.
  task automatic async_reset();
    @(negedge clk);
    #5;
    rst = 1'b1;
    model_reset();
    #1;
    check_both();
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int last_ls, last_fs, hs_low;
    bit prev_fs;

    rst = 1'b1;
    ce  = 1'b0;
    model_reset();
    #1;
    check_both();
    step(1'b0);
    step(1'b1);
    step(1'b0);

    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    check("first.frame_start", fs_a, 1);
    step(1'b1);
    check("second.x", x_a, 1);

    last_ls = -1;
    last_fs = -1;
    hs_low  = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b1);
      if (ls_a) begin
        if (last_ls >= 0) check("a.line_period", cyc - last_ls, 800);
        last_ls = cyc;
      end
      if (fs_b) begin
        if (last_fs >= 0) check("b.frame_period", cyc - last_fs, 128);
        last_fs = cyc;
      end
      if (ay == 1 && !hs_a) hs_low++;
    end
    check("a.h_sync_low_cycles", hs_low, 96);

    last_fs = -1;
    prev_fs = fs_b;
    for (int i = 0; i < 1200; i++) begin
      step(i % 2 == 0);
      if (fs_b && !prev_fs) begin
        if (last_fs >= 0) check("b.half_rate_frame", cyc - last_fs, 256);
        last_fs = cyc;
      end
      prev_fs = fs_b;
    end

    repeat (3000) step(1'($urandom_range(0, 1)));

    repeat ($urandom_range(50, 500)) step(1'b1);
    async_reset();
    step(1'b1);
    check("resume.frame_start", fs_b, 1);

    repeat (1000) step(1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
